bus_decoder: RTL and testbench
==============================

// Module: bus_decoder
// PURPOSE
//   68000-side address decoder and bus-cycle controller for Mackerel-10; sits directly upstream of
//   dram_controller and drives its CS input. Decodes AS/FC/address into DRAM, ROM and DUART selects.
//   Merges per-target DTACK sources into a single CPU DTACK and maps ROM over vector space after reset.
//   Autovectors IACK cycles and raises BERR on unanswered cycles.
// PARAMETERS
//   ROM_WS       2    clocks from AS sampled low to DTACK for ROM cycles (0..15)
//   BERR_CYCLES  200  clocks of AS low without DTACK before BERR (1..255)
//   DRAM_TOP     4'hE DRAM selected when A[23:20] < DRAM_TOP (0x000000-0xDFFFFF)
//   ROM_NIB      4'hF ROM: A[23:20]==ROM_NIB and A[19]==0 (0xF00000-0xF7FFFF)
//   DUART_BASE   9'h1FF DUART: A[23:15]==DUART_BASE (0xFF8000-0xFFFFFF)
// PORTS
//   CLK         in  1   CPU clock
//   RST         in  1   async reset, active-low
//   AS          in  1   CPU address strobe, active-low
//   RW          in  1   1=read, 0=write
//   FC          in  3   CPU function code
//   ADDR_IN     in  23  CPU A[23:1]
//   DTACK_DRAM  in  1   DTACK from dram_controller, active-low
//   DTACK_DUART in  1   DTACK from DUART, active-low
//   CS_DRAM     out 1   DRAM select to dram_controller, active-low
//   CS_ROM      out 1   ROM select, active-low
//   CS_DUART    out 1   DUART select, active-low
//   DTACK       out 1   merged DTACK to CPU, active-low
//   VPA         out 1   autovector request, active-low
//   BERR        out 1   bus error to CPU, active-low
// BEHAVIOUR
//   Reset (RST=0): all outputs 1; FSM=IDLE; counter=0; OVERLAY=1.
//   Decode (combinational, qualified by AS=0 and RST=1; exactly one or none active):
//   - FC==3'b111: IACK; no CS; VPA=0 while AS=0.
//   - OVERLAY=1 and A[23:3]==0 (0x000000-0x000007): CS_ROM (vector fetch), never CS_DRAM.
//   - else DRAM/ROM/DUART per parameters; anything else unmapped.
//   - Writes to ROM region: CS_ROM stays 1; cycle is treated as unmapped.
//   FSM (registered, rising CLK edge):
//   - IDLE: AS sampled 0 -> ACTIVE, counter=0.
//   - ACTIVE: counter+1 per clock, saturating at 255. ROM: DTACK=0 once counter>=ROM_WS.
//     DRAM: DTACK follows DTACK_DRAM. DUART: DTACK follows DTACK_DUART.
//     DTACK=0 -> DONE.
//   - DONE: hold DTACK/VPA low until AS sampled 1 -> IDLE.
//   - ACTIVE, no DTACK, counter==BERR_CYCLES-1 -> BERR=0 from next clock, TIMEOUT.
//   - TIMEOUT: hold BERR=0 until AS sampled 1 -> IDLE.
//   - AS high in any state: DTACK, BERR and VPA gated to 1 combinationally in that same cycle.
//     FSM returns to IDLE at the next edge. Covers mid-cycle abort.
//   - Target DTACK and timeout on the same edge: DTACK wins, BERR stays 1.
//   - ROM_WS=0: DTACK=0 the first clock after AS is sampled.
//   OVERLAY: cleared at the AS rising edge ending any cycle with A[23:20]==ROM_NIB.
//     Cleared by the first fetch from real ROM space after the reset vectors. Set only by reset.
//   Async reset mid-cycle: outputs 1 immediately; OVERLAY re-armed.
// CONFIGURATION
//   BERR_WATCHDOG_EN defined: watchdog and TIMEOUT state present as above.
//   BERR_WATCHDOG_EN undefined: BERR tied 1, TIMEOUT removed.
//     Unmapped cycles stay in ACTIVE until AS high (CPU hangs); counter only serves ROM_WS.
// TESTING
//   1. RST low 1us, release; read 0x000000 and 0x000004 -> CS_ROM=0, CS_DRAM=1; DTACK 2 clk after AS.
//   2. Read 0xF00008 then 0x000000 -> first cycle clears OVERLAY; second gives CS_DRAM=0, CS_ROM=1.
//   3. Read 0x120034 after overlay cleared; dram_controller model returns DTACK_DRAM after 3 clk.
//      Expect CS_DRAM=0 and DTACK=0 on the same clock as DTACK_DRAM; release within 1 clk of AS high.
//   4. Read 0xE00000 with BERR_WATCHDOG_EN -> BERR=0 exactly 200 clk after AS sampled; DTACK stays 1.
//      Without the macro, BERR stays 1 for 1000 clk.
//   5. FC=111, A=0xFFFFF5 -> VPA=0, all CS=1; write to 0xF00000 -> CS_ROM=1, BERR at timeout.
//   6. Raise AS 1 clk into a ROM_WS=2 cycle -> no DTACK, FSM IDLE; pull RST low mid-DRAM cycle.
//      Expect all outputs 1 and OVERLAY=1.

Source files
------------

// File: rtl/bus_decoder.sv
// bus_decoder: Mackerel-10 68000 address decoder, DTACK merger and bus-cycle controller.
// Define BERR_WATCHDOG_EN to add the bus-error watchdog and its TIMEOUT state.
module bus_decoder #(
    parameter int unsigned ROM_WS      = 2,
    parameter int unsigned BERR_CYCLES = 200,
    parameter logic [3:0]  DRAM_TOP    = 4'hE,
    parameter logic [3:0]  ROM_NIB     = 4'hF,
    parameter logic [8:0]  DUART_BASE  = 9'h1FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        as_n,
    input  logic        rw,
    input  logic [2:0]  fc,
    input  logic [22:0] addr_in,
    input  logic        dtack_dram_n,
    input  logic        dtack_duart_n,
    output logic        cs_dram_n,
    output logic        cs_rom_n,
    output logic        cs_duart_n,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr_n
);

`ifdef BERR_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, TIMEOUT} state_t;
    localparam logic [7:0] BERR_LAST = 8'(BERR_CYCLES - 1);
`else
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
`endif

    localparam logic [7:0] ROM_WS_LAST = 8'(ROM_WS - 1);

    if (ROM_WS > 15 || BERR_CYCLES == 0 || BERR_CYCLES > 255) begin : g_param_check
        $error("bus_decoder: ROM_WS must be 0..15 and BERR_CYCLES 1..255");
    end

    state_t     state;
    logic [7:0] count;
    logic       overlay;
    logic       rom_cycle;
    logic       rom_ready;

    logic cycle_on;
    logic is_iack;
    logic is_vector;
    logic in_dram;
    logic in_rom;
    logic in_duart;
    logic sel_dram;
    logic sel_rom;
    logic sel_duart;
    logic target_ack;

    assign cycle_on  = !as_n && rst_n;
    assign is_iack   = (fc == 3'b111);
    assign is_vector = overlay && ({addr_in, 1'b0} < 24'h000008);
    assign in_dram   = (addr_in[22:19] < DRAM_TOP);
    assign in_rom    = (addr_in[22:19] == ROM_NIB) && !addr_in[18];
    assign in_duart  = (addr_in[22:14] == DUART_BASE);

    // Target decode; ROM only answers reads, so a ROM write falls through as unmapped.
    always_comb begin
        sel_dram  = 1'b0;
        sel_rom   = 1'b0;
        sel_duart = 1'b0;
        if (!is_iack) begin
            if (is_vector) begin
                sel_rom = rw;
            end else if (in_dram) begin
                sel_dram = 1'b1;
            end else if (in_rom) begin
                sel_rom = rw;
            end else if (in_duart) begin
                sel_duart = 1'b1;
            end
        end
    end

    // Acknowledge from whichever target owns the cycle; VPA counts as the IACK answer.
    always_comb begin
        target_ack = 1'b0;
        if (is_iack) begin
            target_ack = 1'b1;
        end else if (sel_rom) begin
            target_ack = rom_ready;
        end else if (sel_dram) begin
            target_ack = !dtack_dram_n;
        end else if (sel_duart) begin
            target_ack = !dtack_duart_n;
        end
    end

    // Cycle FSM: any sampled AS high ends the cycle and drops the overlay after a ROM-space cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            overlay   <= 1'b1;
            rom_cycle <= 1'b0;
            rom_ready <= 1'b0;
        end else if (as_n) begin
            if (state != IDLE && rom_cycle) begin
                overlay <= 1'b0;
            end
            state     <= IDLE;
            count     <= '0;
            rom_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= ACTIVE;
                    count     <= '0;
                    rom_cycle <= (addr_in[22:19] == ROM_NIB);
                    rom_ready <= (ROM_WS == 0);
                end
                ACTIVE: begin
                    if (count != 8'hFF) begin
                        count <= count + 8'd1;
                    end
                    if (count == ROM_WS_LAST) begin
                        rom_ready <= 1'b1;
                    end
                    if (target_ack) begin
                        state <= DONE;
`ifdef BERR_WATCHDOG_EN
                    end else if (count == BERR_LAST) begin
                        state <= TIMEOUT;
`endif
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign cs_dram_n  = !(cycle_on && sel_dram);
    assign cs_rom_n   = !(cycle_on && sel_rom);
    assign cs_duart_n = !(cycle_on && sel_duart);
    assign vpa_n      = !(cycle_on && is_iack);
    assign dtack_n    = !(cycle_on && !is_iack &&
                          ((state == ACTIVE && target_ack) || state == DONE));

`ifdef BERR_WATCHDOG_EN
    assign berr_n = !(cycle_on && state == TIMEOUT);
`else
    assign berr_n = 1'b1;
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: directed and randomized bus cycles against an address-map reference model.
// Two instances share the bus: defaults, and ROM_WS=0 / BERR_CYCLES=1 for the edge cases.
module tb_bus_decoder;

    localparam int ROM_WS      = 2;
    localparam int BERR_CYCLES = 200;
    localparam int W0_ROM_WS   = 0;
    localparam int W0_BERR     = 1;
    localparam int NEVER       = 1000000;
`ifdef BERR_WATCHDOG_EN
    localparam bit WATCHDOG = 1'b1;
`else
    localparam bit WATCHDOG = 1'b0;
`endif

    typedef enum int {T_NONE, T_DRAM, T_ROM, T_DUART, T_IACK} tgt_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        as_n;
    logic        rw;
    logic [2:0]  fc;
    logic [22:0] addr_in;
    logic        dtack_dram_n;
    logic        dtack_duart_n;

    logic cs_dram_n, cs_rom_n, cs_duart_n, dtack_n, vpa_n, berr_n;
    logic w0_cs_dram_n, w0_cs_rom_n, w0_cs_duart_n, w0_dtack_n, w0_vpa_n, w0_berr_n;

    int tests_run;
    int tests_failed;
    bit overlay_m;

    always #5 clk = ~clk;

    bus_decoder #(.ROM_WS(ROM_WS), .BERR_CYCLES(BERR_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .as_n(as_n), .rw(rw), .fc(fc), .addr_in(addr_in),
        .dtack_dram_n(dtack_dram_n), .dtack_duart_n(dtack_duart_n),
        .cs_dram_n(cs_dram_n), .cs_rom_n(cs_rom_n), .cs_duart_n(cs_duart_n),
        .dtack_n(dtack_n), .vpa_n(vpa_n), .berr_n(berr_n)
    );

    bus_decoder #(.ROM_WS(W0_ROM_WS), .BERR_CYCLES(W0_BERR)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .as_n(as_n), .rw(rw), .fc(fc), .addr_in(addr_in),
        .dtack_dram_n(dtack_dram_n), .dtack_duart_n(dtack_duart_n),
        .cs_dram_n(w0_cs_dram_n), .cs_rom_n(w0_cs_rom_n), .cs_duart_n(w0_cs_duart_n),
        .dtack_n(w0_dtack_n), .vpa_n(w0_vpa_n), .berr_n(w0_berr_n)
    );

    // Reference memory map, written as byte-address ranges.
    function automatic tgt_t decodeRef(input logic [23:0] a, input logic is_read,
                                       input logic [2:0] f, input bit ovl);
        if (f == 3'd7) return T_IACK;
        if (ovl && a < 24'h000008) return is_read ? T_ROM : T_NONE;
        if (a < 24'hE00000) return T_DRAM;
        if (a >= 24'hF00000 && a < 24'hF80000) return is_read ? T_ROM : T_NONE;
        if (a >= 24'hFF8000) return T_DUART;
        return T_NONE;
    endfunction

    // Clock index (counted from the edge that samples AS low) at which the target answers.
    function automatic int ackClock(input tgt_t t, input int rom_ws, input int delay);
        case (t)
            T_ROM:   return rom_ws;
            T_DRAM:  return delay;
            T_DUART: return delay;
            T_IACK:  return 0;
            default: return NEVER;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " cs_dram idle"},     cs_dram_n,     1'b1);
        checkOutput({name, " cs_rom idle"},      cs_rom_n,      1'b1);
        checkOutput({name, " cs_duart idle"},    cs_duart_n,    1'b1);
        checkOutput({name, " dtack idle"},       dtack_n,       1'b1);
        checkOutput({name, " vpa idle"},         vpa_n,         1'b1);
        checkOutput({name, " berr idle"},        berr_n,        1'b1);
        checkOutput({name, " w0 cs_dram idle"},  w0_cs_dram_n,  1'b1);
        checkOutput({name, " w0 cs_rom idle"},   w0_cs_rom_n,   1'b1);
        checkOutput({name, " w0 cs_duart idle"}, w0_cs_duart_n, 1'b1);
        checkOutput({name, " w0 dtack idle"},    w0_dtack_n,    1'b1);
        checkOutput({name, " w0 vpa idle"},      w0_vpa_n,      1'b1);
        checkOutput({name, " w0 berr idle"},     w0_berr_n,     1'b1);
    endtask

    task automatic checkHandshake(input string name, input int k, input tgt_t t, input int ack,
                                  input int limit, input logic dt, input logic be, input logic vp);
        logic exp_dt;
        logic exp_be;
        exp_dt = (t != T_IACK && t != T_NONE && k >= ack && (!WATCHDOG || ack < limit)) ? 1'b0 : 1'b1;
        exp_be = (WATCHDOG && ack >= limit && k >= limit) ? 1'b0 : 1'b1;
        checkOutput($sformatf("%s k=%0d dtack", name, k), dt, exp_dt);
        checkOutput($sformatf("%s k=%0d berr", name, k), be, exp_be);
        checkOutput($sformatf("%s k=%0d vpa", name, k), vp, (t == T_IACK) ? 1'b0 : 1'b1);
    endtask

    // One complete CPU bus cycle, with DRAM/DUART models answering 'delay' clocks after AS is sampled.
    task automatic applyStimulus(input string name, input logic [23:0] a, input logic is_read,
                                 input logic [2:0] f, input int delay, input int hold);
        tgt_t t;
        int   ack_main;
        int   ack_w0;
        t        = decodeRef(a, is_read, f, overlay_m);
        ack_main = ackClock(t, ROM_WS, delay);
        ack_w0   = ackClock(t, W0_ROM_WS, delay);
        @(negedge clk);
        addr_in = a[23:1];
        rw      = is_read;
        fc      = f;
        as_n    = 1'b0;
        #1;
        checkOutput({name, " cs_dram"},     cs_dram_n,     (t == T_DRAM)  ? 1'b0 : 1'b1);
        checkOutput({name, " cs_rom"},      cs_rom_n,      (t == T_ROM)   ? 1'b0 : 1'b1);
        checkOutput({name, " cs_duart"},    cs_duart_n,    (t == T_DUART) ? 1'b0 : 1'b1);
        checkOutput({name, " w0 cs_dram"},  w0_cs_dram_n,  (t == T_DRAM)  ? 1'b0 : 1'b1);
        checkOutput({name, " w0 cs_rom"},   w0_cs_rom_n,   (t == T_ROM)   ? 1'b0 : 1'b1);
        checkOutput({name, " w0 cs_duart"}, w0_cs_duart_n, (t == T_DUART) ? 1'b0 : 1'b1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (t == T_DRAM && k >= delay) dtack_dram_n = 1'b0;
            if (t == T_DUART && k >= delay) dtack_duart_n = 1'b0;
            #1;
            checkHandshake(name, k, t, ack_main, BERR_CYCLES, dtack_n, berr_n, vpa_n);
            checkHandshake({name, " w0"}, k, t, ack_w0, W0_BERR, w0_dtack_n, w0_berr_n, w0_vpa_n);
        end
        @(negedge clk);
        as_n = 1'b1;
        #1;
        checkIdle({name, " end"});
        @(posedge clk);
        #1;
        dtack_dram_n  = 1'b1;
        dtack_duart_n = 1'b1;
        if (a[23:20] == 4'hF) overlay_m = 1'b0;
    endtask

    initial begin
        logic [23:0] ra;
        logic        rd;
        logic [2:0]  rf;
        int          cls;
        int          rdelay;

        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        as_n          = 1'b0;
        rw            = 1'b1;
        fc            = 3'd6;
        addr_in       = '0;
        dtack_dram_n  = 1'b1;
        dtack_duart_n = 1'b1;
        overlay_m     = 1'b1;

        // Reset holds everything inactive even with AS asserted.
        #20;
        checkIdle("reset");
        #980;
        as_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus("t1_vec0", 24'h000000, 1'b1, 3'd6, 0, 4);
        applyStimulus("t1_vec4", 24'h000004, 1'b1, 3'd6, 0, 4);
        applyStimulus("t2_rom", 24'hF00008, 1'b1, 3'd6, 0, 4);
        applyStimulus("t2_dram0", 24'h000000, 1'b1, 3'd5, 1, 4);
        applyStimulus("t3_dram", 24'h120034, 1'b1, 3'd5, 3, 6);
        applyStimulus("t4_unmapped", 24'hE00000, 1'b1, 3'd5, 0, WATCHDOG ? BERR_CYCLES + 5 : 1000);
        applyStimulus("t5_iack", 24'hFFFFF5, 1'b1, 3'd7, 0, 6);
        applyStimulus("t5_romwr", 24'hF00000, 1'b0, 3'd5, 0, WATCHDOG ? BERR_CYCLES + 5 : 20);
        applyStimulus("same_edge", 24'h000100, 1'b1, 3'd5, BERR_CYCLES - 1, BERR_CYCLES + 3);
        applyStimulus("duart_rd", 24'hFF8000, 1'b1, 3'd5, 2, 5);
        applyStimulus("duart_wr", 24'hFFFFFE, 1'b0, 3'd1, 0, 3);
        applyStimulus("dram_top", 24'hDFFFFE, 1'b0, 3'd1, 0, 3);
        applyStimulus("rom_top", 24'hF7FFFE, 1'b1, 3'd6, 0, 4);
        applyStimulus("gap_rom_duart", 24'hF80000, 1'b1, 3'd5, 0, 4);
        applyStimulus("gap_below_duart", 24'hFF7FFE, 1'b1, 3'd5, 0, 4);
        applyStimulus("t6_abort", 24'hF00010, 1'b1, 3'd6, 0, 2);

        // Async reset in the middle of an acknowledged DRAM cycle re-arms the overlay.
        @(negedge clk);
        addr_in = 23'h09001A;
        rw      = 1'b1;
        fc      = 3'd5;
        as_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dtack_dram_n = 1'b0;
        #1;
        checkOutput("t6_dram dtack", dtack_n, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("t6_rst");
        overlay_m     = 1'b1;
        as_n          = 1'b1;
        dtack_dram_n  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus("t6_vec", 24'h000000, 1'b1, 3'd6, 0, 4);
        applyStimulus("t6_rom", 24'hF00000, 1'b1, 3'd6, 0, 4);

        for (int i = 0; i < 40; i++) begin
            cls    = int'($urandom_range(0, 5));
            rdelay = int'($urandom_range(0, 5));
            rd     = 1'($urandom_range(0, 1));
            rf     = 3'($urandom_range(1, 6));
            case (cls)
                0: ra = 24'($urandom_range(0, 32'hDFFFFF));
                1: begin ra = 24'hF00000 + 24'($urandom_range(0, 32'h7FFFF)); rd = 1'b1; end
                2: begin ra = 24'hF00000 + 24'($urandom_range(0, 32'h7FFFF)); rd = 1'b0; end
                3: ra = 24'hFF8000 + 24'($urandom_range(0, 32'h7FFF));
                4: ra = 24'hE00000 + 24'($urandom_range(0, 32'hFFFFF));
                default: begin ra = 24'($urandom_range(0, 32'hFFFFFF)); rf = 3'd7; end
            endcase
            if (rf != 3'd7) ra[0] = 1'b0;
            applyStimulus($sformatf("rand%0d", i), ra, rd, rf, rdelay, 8);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
